mem_fetch_unit: RTL and testbench

Memory-side front end of the multicycle TSC processor, upstream of the control unit. Turns the control unit's level commands (read, write, address select, IR write) into a request/acknowledge handshake with external 16-bit memory. Holds the instruction register and memory data register, and supplies decoded instruction fields (opcode, funct, register indices, immediates) to the control unit and datapath. Signals completion with a one-cycle `mem_done` pulse, on which the control unit advances state.

---
 rtl/mem_fetch_unit.sv | 160 ++++++++++++++++
 tb/tb_mem_fetch_unit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_fetch_unit.sv
// Memory-side front end of the multicycle TSC processor: turns control-unit level
// commands into a strobe/response handshake and holds IR, MDR and decoded fields.
module mem_fetch_unit #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        iord,
  input  logic        ir_write,
  input  logic [15:0] pc,
  input  logic [15:0] alu_out,
  input  logic [15:0] wdata,
  output logic        readM,
  output logic        writeM,
  output logic [15:0] address,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        input_ready,
  input  logic        ack_output,
  output logic        mem_done,
  output logic        busy,
  output logic [15:0] instr,
  output logic [15:0] mdr,
  output logic [3:0]  opcode,
  output logic [1:0]  rs,
  output logic [1:0]  rt,
  output logic [1:0]  rd,
  output logic [5:0]  funct,
  output logic [15:0] imm_se,
  output logic [11:0] target,
  output logic        timeout_err,
  output logic        protocol_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_REQ = 2'd1,
    WR_REQ = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             ir_dest;
  logic             rd_cmd;
  logic             wr_cmd;
  logic             last_cycle;

  assign rd_cmd     = mem_read & ~mem_write;
  assign wr_cmd     = mem_write & ~mem_read;
  // Counter holds k-1 during the k-th strobe cycle, so the strobe lasts exactly TIMEOUT cycles.
  assign last_cycle = (cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (rd_cmd) begin
          state_nxt = RD_REQ;
        end else if (wr_cmd) begin
          state_nxt = WR_REQ;
        end
      end
      RD_REQ: begin
        if (input_ready || last_cycle) begin
          state_nxt = DONE;
        end
      end
      WR_REQ: begin
        if (ack_output || last_cycle) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Strobes and status decode straight from state so reset drops them at once.
  assign readM    = (state == RD_REQ);
  assign writeM   = (state == WR_REQ);
  assign busy     = (state == RD_REQ) || (state == WR_REQ);
  assign mem_done = (state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      address      <= '0;
      mem_wdata    <= '0;
      instr        <= '0;
      mdr          <= '0;
      ir_dest      <= 1'b0;
      cnt          <= '0;
      timeout_err  <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (rd_cmd || wr_cmd) begin
            address <= iord ? alu_out : pc;
            cnt     <= '0;
          end
          if (rd_cmd) begin
            ir_dest <= ir_write;
          end
          if (wr_cmd) begin
            mem_wdata <= wdata;
          end
          if (mem_read && mem_write) begin
            protocol_err <= 1'b1;
          end
        end
        RD_REQ: begin
          cnt <= cnt + CNT_W'(1);
          if (input_ready) begin
            if (ir_dest) begin
              instr <= mem_rdata;
            end else begin
              mdr <= mem_rdata;
            end
          end else if (last_cycle) begin
            timeout_err <= 1'b1;
          end
        end
        WR_REQ: begin
          cnt <= cnt + CNT_W'(1);
          if (!ack_output && last_cycle) begin
            timeout_err <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign opcode = instr[15:12];
  assign rs     = instr[11:10];
  assign rt     = instr[9:8];
  assign rd     = instr[7:6];
  assign funct  = instr[5:0];
  assign imm_se = {{8{instr[7]}}, instr[7:0]};
  assign target = instr[11:0];

endmodule

// File: tb/tb_mem_fetch_unit.sv
// Directed self-checking bench for mem_fetch_unit, built with a short timeout of 4 cycles.
module tb_mem_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read, mem_write, iord, ir_write;
  logic [15:0] pc, alu_out, wdata, mem_rdata;
  logic        input_ready, ack_output;
  logic        readM, writeM, mem_done, busy, timeout_err, protocol_err;
  logic [15:0] address, mem_wdata, instr, mdr, imm_se;
  logic [3:0]  opcode;
  logic [1:0]  rs, rt, rd;
  logic [5:0]  funct;
  logic [11:0] target;

  int assert_count = 0;
  int fail_count   = 0;

  mem_fetch_unit #(.TIMEOUT(4), .CNT_W(3)) dut (
    .clk(clk), .reset(reset),
    .mem_read(mem_read), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
    .pc(pc), .alu_out(alu_out), .wdata(wdata),
    .readM(readM), .writeM(writeM), .address(address), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .input_ready(input_ready), .ack_output(ack_output),
    .mem_done(mem_done), .busy(busy), .instr(instr), .mdr(mdr),
    .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .funct(funct),
    .imm_se(imm_se), .target(target),
    .timeout_err(timeout_err), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
    assert_count++;
    assert (observed === expected) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge, where outputs are sampled and inputs driven.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    mem_read = 0; mem_write = 0; iord = 0; ir_write = 0;
    pc = '0; alu_out = '0; wdata = '0; mem_rdata = '0;
    input_ready = 0; ack_output = 0;
    #2;
    check_output("rst_readM", 16'(readM), 16'h0);
    check_output("rst_writeM", 16'(writeM), 16'h0);
    check_output("rst_done", 16'(mem_done), 16'h0);
    check_output("rst_busy", 16'(busy), 16'h0);
    check_output("rst_instr", instr, 16'h0000);
    check_output("rst_mdr", mdr, 16'h0000);
    check_output("rst_addr", address, 16'h0000);
    check_output("rst_errs", {14'h0, timeout_err, protocol_err}, 16'h0);
    next_cycle();
    reset = 1'b0;
    next_cycle();

    $display("[TB] fetch");
    mem_read = 1; ir_write = 1; iord = 0; pc = 16'h0010;
    next_cycle();
    mem_read = 0; pc = 16'h0011;
    check_output("fetch_readM", 16'(readM), 16'h1);
    check_output("fetch_busy", 16'(busy), 16'h1);
    check_output("fetch_addr", address, 16'h0010);
    check_output("fetch_done_early", 16'(mem_done), 16'h0);
    input_ready = 1; mem_rdata = 16'h6A05;
    next_cycle();
    input_ready = 0; mem_rdata = 16'h0000;
    check_output("fetch_done", 16'(mem_done), 16'h1);
    check_output("fetch_readM_off", 16'(readM), 16'h0);
    check_output("fetch_instr", instr, 16'h6A05);
    check_output("fetch_opcode", 16'(opcode), 16'h6);
    check_output("fetch_rs", 16'(rs), 16'h2);
    check_output("fetch_rt", 16'(rt), 16'h2);
    check_output("fetch_rd", 16'(rd), 16'h0);
    check_output("fetch_funct", 16'(funct), 16'h5);
    check_output("fetch_imm", imm_se, 16'h0005);
    check_output("fetch_target", 16'(target), 16'h0A05);
    check_output("fetch_mdr", mdr, 16'h0000);
    next_cycle();
    check_output("fetch_done_pulse", 16'(mem_done), 16'h0);
    check_output("fetch_idle_busy", 16'(busy), 16'h0);

    $display("[TB] stray response in idle");
    input_ready = 1; mem_rdata = 16'hDEAD;
    next_cycle();
    input_ready = 0;
    check_output("idle_resp_mdr", mdr, 16'h0000);
    check_output("idle_resp_busy", 16'(busy), 16'h0);

    $display("[TB] load with delay");
    mem_read = 1; iord = 1; alu_out = 16'h0100; ir_write = 0;
    next_cycle();
    mem_read = 0; alu_out = 16'h0200;
    check_output("load_c1_addr", address, 16'h0100);
    check_output("load_c1_readM", 16'(readM), 16'h1);
    next_cycle();
    check_output("load_c2_addr", address, 16'h0100);
    check_output("load_c2_done", 16'(mem_done), 16'h0);
    next_cycle();
    check_output("load_c3_addr", address, 16'h0100);
    check_output("load_c3_readM", 16'(readM), 16'h1);
    input_ready = 1; mem_rdata = 16'hBEEF;
    next_cycle();
    input_ready = 0;
    check_output("load_done", 16'(mem_done), 16'h1);
    check_output("load_mdr", mdr, 16'hBEEF);
    check_output("load_instr", instr, 16'h6A05);
    check_output("load_addr_hold", address, 16'h0100);
    next_cycle();
    check_output("load_idle", 16'(mem_done), 16'h0);

    $display("[TB] store");
    mem_write = 1; alu_out = 16'h0020; wdata = 16'h1234;
    next_cycle();
    mem_write = 0; wdata = 16'h9999;
    input_ready = 1; mem_rdata = 16'h5555;
    check_output("store_c1_writeM", 16'(writeM), 16'h1);
    check_output("store_c1_readM", 16'(readM), 16'h0);
    check_output("store_addr", address, 16'h0020);
    check_output("store_wdata", mem_wdata, 16'h1234);
    next_cycle();
    input_ready = 0;
    check_output("store_c2_writeM", 16'(writeM), 16'h1);
    check_output("store_c2_done", 16'(mem_done), 16'h0);
    check_output("store_c2_wdata", mem_wdata, 16'h1234);
    ack_output = 1;
    next_cycle();
    ack_output = 0;
    check_output("store_done", 16'(mem_done), 16'h1);
    check_output("store_writeM_off", 16'(writeM), 16'h0);
    check_output("store_mdr", mdr, 16'hBEEF);
    check_output("store_instr", instr, 16'h6A05);
    next_cycle();
    check_output("store_done_pulse", 16'(mem_done), 16'h0);

    $display("[TB] timeout");
    mem_read = 1; ir_write = 1; iord = 0; pc = 16'h0030;
    next_cycle();
    mem_read = 0;
    for (int i = 0; i < 4; i++) begin
      check_output($sformatf("to_readM_c%0d", i + 1), 16'(readM), 16'h1);
      check_output($sformatf("to_done_c%0d", i + 1), 16'(mem_done), 16'h0);
      next_cycle();
    end
    check_output("to_readM_off", 16'(readM), 16'h0);
    check_output("to_done", 16'(mem_done), 16'h1);
    check_output("to_err", 16'(timeout_err), 16'h1);
    check_output("to_instr", instr, 16'h6A05);
    check_output("to_mdr", mdr, 16'hBEEF);
    next_cycle();
    mem_read = 1; ir_write = 0; iord = 1; alu_out = 16'h0040;
    next_cycle();
    mem_read = 0;
    check_output("after_to_addr", address, 16'h0040);
    input_ready = 1; mem_rdata = 16'h0042;
    next_cycle();
    input_ready = 0;
    check_output("after_to_done", 16'(mem_done), 16'h1);
    check_output("after_to_mdr", mdr, 16'h0042);
    check_output("after_to_err", 16'(timeout_err), 16'h1);
    next_cycle();

    $display("[TB] illegal command");
    mem_read = 1; mem_write = 1;
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      check_output("ill_strobes", {14'h0, readM, writeM}, 16'h0);
      check_output("ill_done", 16'(mem_done), 16'h0);
      check_output("ill_busy", 16'(busy), 16'h0);
      check_output("ill_perr", 16'(protocol_err), 16'h1);
    end
    mem_read = 0; mem_write = 0;
    next_cycle();

    $display("[TB] reset mid-access");
    mem_read = 1; ir_write = 1; iord = 0; pc = 16'h0050;
    next_cycle();
    mem_read = 0;
    next_cycle();
    check_output("rm_c2_readM", 16'(readM), 16'h1);
    #2;
    reset = 1'b1;
    #1;
    check_output("rm_readM", 16'(readM), 16'h0);
    check_output("rm_instr", instr, 16'h0000);
    check_output("rm_busy", 16'(busy), 16'h0);
    check_output("rm_done", 16'(mem_done), 16'h0);
    check_output("rm_errs", {14'h0, timeout_err, protocol_err}, 16'h0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      check_output("rm_idle_busy", 16'(busy), 16'h0);
      check_output("rm_idle_done", 16'(mem_done), 16'h0);
      check_output("rm_idle_readM", 16'(readM), 16'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
